lpddr3_lane_rx_capture: RTL

- Receive-side companion to the LPDDR3 lane transmit IOD path.
- Consumes 1:8 deserialized read data from a lane's DQ IODs, all in the FAB_CLK domain.
- Runs bit-slip read training against a fixed pattern.
- After training, uses a read-latency pipeline to gate captured bursts into RD_DATA/RD_VALID for the DDR controller.

---
 rtl/lpddr3_rx_pkg.sv | 16 +
 rtl/lpddr3_rx_pin_align.sv | 68 ++++++
 rtl/lpddr3_lane_rx_capture.sv | 126 ++++++++++++
 3 files changed

// File: rtl/lpddr3_rx_pkg.sv
// Shared types and widths for the LPDDR3 lane receive capture path.
package lpddr3_rx_pkg;
  localparam int RATIO       = 8;
  localparam int SLIP_CNT_W  = 3;
  localparam int MATCH_CNT_W = 4;

  localparam logic [SLIP_CNT_W-1:0] SLIP_MAX = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } rx_state_e;
endpackage

// File: rtl/lpddr3_rx_pin_align.sv
// Per-pin bit-slip alignment: match/slip counters, lock/fail flags and slip pulse.
// Optional LPDDR3_RX_SLIP_STATUS_EN exposes the slip counter.
module lpddr3_rx_pin_align
  import lpddr3_rx_pkg::*;
#(
  parameter logic [RATIO-1:0] TRAIN_PATTERN = 8'h0F,
  parameter int               MATCH_COUNT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             check,
  input  logic [RATIO-1:0] rx_word,
  output logic             lock_nxt,
  output logic             fail_nxt,
  output logic             slip
`ifdef LPDDR3_RX_SLIP_STATUS_EN
  ,
  output logic [SLIP_CNT_W-1:0] slip_cnt_o
`endif
);
  localparam logic [MATCH_CNT_W-1:0] MATCH_TGT = MATCH_CNT_W'(MATCH_COUNT);

  logic [MATCH_CNT_W-1:0] match_cnt;
  logic [MATCH_CNT_W-1:0] match_inc;
  logic [SLIP_CNT_W-1:0]  slip_cnt;
  logic                   lock;
  logic                   fail;
  logic                   active;
  logic                   match;

  // Locked or failed pins drop out of the check entirely.
  always_comb begin
    active    = check && !lock && !fail;
    match     = (rx_word == TRAIN_PATTERN);
    match_inc = match_cnt + 1'b1;
    lock_nxt  = lock || (active && match && (match_inc == MATCH_TGT));
    fail_nxt  = fail || (active && !match && (slip_cnt == SLIP_MAX));
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      match_cnt <= '0;
      slip_cnt  <= '0;
      lock      <= 1'b0;
      fail      <= 1'b0;
      slip      <= 1'b0;
    end else begin
      slip <= 1'b0;
      if (active) begin
        if (match) begin
          match_cnt <= match_inc;
          lock      <= lock_nxt;
        end else if (slip_cnt != SLIP_MAX) begin
          match_cnt <= '0;
          slip_cnt  <= slip_cnt + 1'b1;
          slip      <= 1'b1;
        end else begin
          fail <= 1'b1;
        end
      end
    end
  end

`ifdef LPDDR3_RX_SLIP_STATUS_EN
  assign slip_cnt_o = slip_cnt;
`endif
endmodule

// File: rtl/lpddr3_lane_rx_capture.sv
// LPDDR3 lane read capture: bit-slip training FSM plus read-latency gating.
// Optional LPDDR3_RX_SLIP_STATUS_EN adds the SLIP_COUNT status port.
module lpddr3_lane_rx_capture
  import lpddr3_rx_pkg::*;
#(
  parameter int          DQ_WIDTH      = 8,
  parameter logic [7:0]  TRAIN_PATTERN = 8'h0F,
  parameter int          MATCH_COUNT   = 4,
  parameter int          SLIP_WAIT     = 4,
  parameter int          RD_LAT_MAX    = 31
) (
  input  logic                      FAB_CLK,
  input  logic                      RESET_N,
  input  logic [DQ_WIDTH*RATIO-1:0] RX_DATA,
  input  logic                      TRAIN_START,
  output logic                      TRAIN_DONE,
  output logic                      TRAIN_FAIL,
  output logic [DQ_WIDTH-1:0]       RX_BIT_SLIP,
  input  logic                      RD_CMD,
  input  logic [4:0]                RD_LATENCY,
  output logic [DQ_WIDTH*RATIO-1:0] RD_DATA,
  output logic                      RD_VALID,
  output logic                      RD_ERR,
  output rx_state_e                 dbg_state
`ifdef LPDDR3_RX_SLIP_STATUS_EN
  ,
  output logic [DQ_WIDTH*SLIP_CNT_W-1:0] SLIP_COUNT
`endif
);
  localparam logic [3:0] WAIT_LAST = 4'(SLIP_WAIT - 1);

  rx_state_e              state;
  rx_state_e              state_nxt;
  logic [3:0]             wait_cnt;
  logic [DQ_WIDTH-1:0]    lock_nxt;
  logic [DQ_WIDTH-1:0]    fail_nxt;
  logic                   check_en;
  logic                   start_ok;
  logic                   restart;
  logic                   wait_done;
  logic [RD_LAT_MAX-1:0]  pipe;
  logic [RD_LAT_MAX:0]    flag;

  for (genvar i = 0; i < DQ_WIDTH; i++) begin : g_pin
    lpddr3_rx_pin_align #(
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .MATCH_COUNT   (MATCH_COUNT)
    ) u_pin (
      .clk        (FAB_CLK),
      .rst_n      (RESET_N),
      .clr        (start_ok),
      .check      (check_en),
      .rx_word    (RX_DATA[RATIO*i +: RATIO]),
      .lock_nxt   (lock_nxt[i]),
      .fail_nxt   (fail_nxt[i]),
      .slip       (RX_BIT_SLIP[i])
`ifdef LPDDR3_RX_SLIP_STATUS_EN
      ,
      .slip_cnt_o (SLIP_COUNT[SLIP_CNT_W*i +: SLIP_CNT_W])
`endif
    );
  end

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (TRAIN_START) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (|fail_nxt)      state_nxt = ST_FAIL;
        else if (&lock_nxt) state_nxt = ST_DONE;
        else                state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (wait_done) state_nxt = ST_CHECK;
      ST_DONE,
      ST_FAIL:  if (TRAIN_START) state_nxt = ST_CHECK;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    check_en  = (state == ST_CHECK);
    restart   = TRAIN_START && ((state == ST_DONE) || (state == ST_FAIL));
    start_ok  = restart || (TRAIN_START && (state == ST_IDLE));
    wait_done = (wait_cnt == WAIT_LAST);
    dbg_state = state;
  end

  // Status flags follow the state they announce, registered alongside it.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      TRAIN_DONE <= 1'b0;
      TRAIN_FAIL <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      TRAIN_DONE <= (state_nxt == ST_DONE);
      TRAIN_FAIL <= (state_nxt == ST_FAIL);
      wait_cnt   <= (state == ST_WAIT) ? wait_cnt + 1'b1 : 4'd0;
    end
  end

  // Tap 0 is the command itself, so RD_LATENCY=0 captures in the command cycle.
  assign flag = {pipe, RD_CMD && TRAIN_DONE};

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      pipe     <= '0;
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
      RD_ERR   <= 1'b0;
    end else if (restart) begin
      pipe     <= '0;
      RD_VALID <= 1'b0;
      RD_ERR   <= 1'b0;
    end else begin
      pipe     <= flag[RD_LAT_MAX-1:0];
      RD_VALID <= flag[RD_LATENCY];
      if (flag[RD_LATENCY]) RD_DATA <= RX_DATA;
      if (RD_CMD && !TRAIN_DONE) RD_ERR <= 1'b1;
    end
  end
endmodule
